// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle control unit for the CISC datapath: sequences fetch, decode
// and execute, runs a MemAck handshake with a bounded wait, and raises
// traps (illegal opcode / memory timeout) and a HALT state with resume.
module unidad_control_multiciclo #(
    parameter int IW       = 16,
    parameter int RAW      = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic           Reloj,
    input  logic           Reiniciar,
    input  logic [IW-1:0]  Instruccion,
    input  logic           StatusFlag,
    input  logic           MemAck,
    input  logic           Continuar,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           LoadIR,
    output logic           LoadAR,
    output logic           SelectAR,
    output logic           LoadDR,
    output logic           SelectDR,
    output logic           LoadPC,
    output logic [1:0]     SelectPC,
    output logic           WriteEnable,
    output logic           WriteSelect,
    output logic [RAW-1:0] WriteAddress,
    output logic [RAW-1:0] ReadAddressA,
    output logic [RAW-1:0] ReadAddressB,
    output logic [3:0]     Fun,
    output logic           LoadS,
    output logic           Halted,
    output logic           Trap,
    output logic [1:0]     Causa,
    output logic [3:0]     Estado
);

    // The instruction word must hold the opcode plus three register fields.
    if (IW < 4 + 3 * RAW) begin : gBadWidth
        $error("unidad_control_multiciclo: IW must be at least 4+3*RAW");
    end

    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic [3:0] {
        FETCH      = 4'd0,
        FETCH_WAIT = 4'd1,
        DECODE     = 4'd2,
        EXEC_ALU   = 4'd3,
        MEM_ADDR   = 4'd4,
        RD_WAIT    = 4'd5,
        WB         = 4'd6,
        ST_DATA    = 4'd7,
        WR_WAIT    = 4'd8,
        JUMP       = 4'd9,
        BRANCH     = 4'd10,
        HALT       = 4'd11,
        TRAP       = 4'd12
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] waitCount_q, waitCount_d;
    logic [1:0]    causa_q, causa_d;

    logic [3:0]     op;
    logic [RAW-1:0] rd, ra, rb;
    logic           timeout;
    logic           unusedBits;

    assign op         = Instruccion[IW-1 -: 4];
    assign rd         = Instruccion[3*RAW-1 -: RAW];
    assign ra         = Instruccion[2*RAW-1 -: RAW];
    assign rb         = Instruccion[RAW-1:0];
    assign unusedBits = ^Instruccion;

    // Last allowed wait cycle with no acknowledge; a late MemAck still wins.
    assign timeout = (MAX_WAIT != 0) && !MemAck && (waitCount_q == LAST_WAIT);

    // Next-state, wait-counter and trap-cause selection.
    always_comb begin
        state_d     = state_q;
        causa_d     = causa_q;
        waitCount_d = '0;
        case (state_q)
            FETCH:      state_d = FETCH_WAIT;
            FETCH_WAIT: begin
                if (MemAck) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                    causa_d = 2'b10;
                end else begin
                    waitCount_d = waitCount_q + WW'(1);
                end
            end
            DECODE: begin
                casez (op)
                    4'b0???: state_d = EXEC_ALU;
                    4'b1000: state_d = MEM_ADDR;
                    4'b1001: state_d = MEM_ADDR;
                    4'b1010: state_d = JUMP;
                    4'b1011: state_d = BRANCH;
                    4'b1111: state_d = HALT;
                    default: begin
                        state_d = TRAP;
                        causa_d = 2'b01;
                    end
                endcase
            end
            EXEC_ALU:   state_d = FETCH;
            MEM_ADDR:   state_d = op[0] ? ST_DATA : RD_WAIT;
            RD_WAIT: begin
                if (MemAck) begin
                    state_d = WB;
                end else if (timeout) begin
                    state_d = TRAP;
                    causa_d = 2'b10;
                end else begin
                    waitCount_d = waitCount_q + WW'(1);
                end
            end
            WB:         state_d = FETCH;
            ST_DATA:    state_d = WR_WAIT;
            WR_WAIT: begin
                if (MemAck) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = TRAP;
                    causa_d = 2'b10;
                end else begin
                    waitCount_d = waitCount_q + WW'(1);
                end
            end
            JUMP:       state_d = FETCH;
            BRANCH:     state_d = FETCH;
            HALT:       state_d = Continuar ? FETCH : HALT;
            TRAP:       state_d = FETCH;
            default:    state_d = FETCH;
        endcase
    end

    // State, wait counter and cause registers with synchronous reset.
    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            state_q     <= FETCH;
            waitCount_q <= '0;
            causa_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            waitCount_q <= waitCount_d;
            causa_q     <= causa_d;
        end
    end

    // Output decode of the current state; everything is forced low in reset.
    always_comb begin
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        LoadIR       = 1'b0;
        LoadAR       = 1'b0;
        SelectAR     = 1'b0;
        LoadDR       = 1'b0;
        SelectDR     = 1'b0;
        LoadPC       = 1'b0;
        SelectPC     = 2'b00;
        WriteEnable  = 1'b0;
        WriteSelect  = 1'b0;
        WriteAddress = '0;
        ReadAddressA = '0;
        ReadAddressB = '0;
        Fun          = 4'b0000;
        LoadS        = 1'b0;
        Halted       = 1'b0;
        Trap         = 1'b0;
        Causa        = causa_q;
        Estado       = state_q;
        case (state_q)
            FETCH:      LoadAR = 1'b1;
            FETCH_WAIT: begin
                MemRead = 1'b1;
                LoadIR  = MemAck;
                LoadPC  = MemAck;
            end
            EXEC_ALU: begin
                ReadAddressA = ra;
                ReadAddressB = rb;
                Fun          = {1'b0, op[2:0]};
                WriteEnable  = 1'b1;
                WriteAddress = rd;
                LoadS        = 1'b1;
            end
            MEM_ADDR: begin
                ReadAddressA = ra;
                SelectAR     = 1'b1;
                LoadAR       = 1'b1;
            end
            RD_WAIT: begin
                MemRead = 1'b1;
                LoadDR  = MemAck;
            end
            WB: begin
                WriteSelect  = 1'b1;
                WriteEnable  = 1'b1;
                WriteAddress = rd;
            end
            ST_DATA: begin
                ReadAddressB = rb;
                SelectDR     = 1'b1;
                LoadDR       = 1'b1;
            end
            WR_WAIT:    MemWrite = 1'b1;
            JUMP: begin
                ReadAddressA = ra;
                LoadPC       = 1'b1;
                SelectPC     = 2'b10;
            end
            BRANCH: begin
                LoadPC   = StatusFlag;
                SelectPC = StatusFlag ? 2'b01 : 2'b00;
            end
            HALT:       Halted = 1'b1;
            TRAP: begin
                Trap     = 1'b1;
                LoadPC   = 1'b1;
                SelectPC = 2'b11;
            end
            default: ;
        endcase
        if (Reiniciar) begin
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            LoadIR       = 1'b0;
            LoadAR       = 1'b0;
            SelectAR     = 1'b0;
            LoadDR       = 1'b0;
            SelectDR     = 1'b0;
            LoadPC       = 1'b0;
            SelectPC     = 2'b00;
            WriteEnable  = 1'b0;
            WriteSelect  = 1'b0;
            WriteAddress = '0;
            ReadAddressA = '0;
            ReadAddressB = '0;
            Fun          = 4'b0000;
            LoadS        = 1'b0;
            Halted       = 1'b0;
            Trap         = 1'b0;
            Causa        = 2'b00;
            Estado       = 4'd0;
        end
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Self-checking bench for unidad_control_multiciclo: builds a per-cycle
// expected trace from instruction-level rules, replays it against the DUT,
// then pins a few hand-computed values directly.
module tb_unidad_control_multiciclo;

    localparam int IW   = 16;
    localparam int RAW  = 3;
    localparam int MAXW = 15;

    logic          Reloj = 1'b0;
    logic          Reiniciar = 1'b1;
    logic [IW-1:0] Instruccion = '0;
    logic          StatusFlag = 1'b0;
    logic          MemAck = 1'b0;
    logic          Continuar = 1'b0;
    logic          MemRead, MemWrite, LoadIR, LoadAR, SelectAR, LoadDR, SelectDR, LoadPC;
    logic [1:0]    SelectPC;
    logic          WriteEnable, WriteSelect;
    logic [RAW-1:0] WriteAddress, ReadAddressA, ReadAddressB;
    logic [3:0]    Fun;
    logic          LoadS, Halted, Trap;
    logic [1:0]    Causa;
    logic [3:0]    Estado;

    unidad_control_multiciclo #(.IW(IW), .RAW(RAW), .MAX_WAIT(MAXW)) dut (
        .Reloj(Reloj), .Reiniciar(Reiniciar), .Instruccion(Instruccion),
        .StatusFlag(StatusFlag), .MemAck(MemAck), .Continuar(Continuar),
        .MemRead(MemRead), .MemWrite(MemWrite), .LoadIR(LoadIR), .LoadAR(LoadAR),
        .SelectAR(SelectAR), .LoadDR(LoadDR), .SelectDR(SelectDR), .LoadPC(LoadPC),
        .SelectPC(SelectPC), .WriteEnable(WriteEnable), .WriteSelect(WriteSelect),
        .WriteAddress(WriteAddress), .ReadAddressA(ReadAddressA), .ReadAddressB(ReadAddressB),
        .Fun(Fun), .LoadS(LoadS), .Halted(Halted), .Trap(Trap), .Causa(Causa), .Estado(Estado)
    );

    always #5 Reloj = ~Reloj;

    typedef struct packed {
        logic       memRead, memWrite, loadIR, loadAR, selectAR, loadDR, selectDR, loadPC;
        logic [1:0] selectPC;
        logic       writeEnable, writeSelect;
        logic [2:0] writeAddress, readA, readB;
        logic [3:0] fun;
        logic       loadS, halted, trap;
        logic [1:0] causa;
        logic [3:0] estado;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic [15:0] instr;
        logic        flag, ack, cont;
        outs_t       exp;
        logic [95:0] tag;
    } cycle_t;

    cycle_t      traceQ[$];
    logic [1:0]  modelCausa = 2'b00;
    logic [15:0] curInstr = '0;
    logic        curFlag = 1'b0;
    logic        idleAck = 1'b0;
    logic        idleCont = 1'b0;
    logic [95:0] curTag = "reset";
    int          checks = 0;
    int          errors = 0;
    int          cycleNo = 0;

    // Expected outputs of a cycle with no strobes, showing a given state.
    function automatic outs_t base(input logic [3:0] st);
        outs_t o;
        o        = '0;
        o.estado = st;
        o.causa  = modelCausa;
        return o;
    endfunction

    task automatic pushCycle(input outs_t o, input logic ack, input logic cont);
        cycle_t c;
        c.rst   = 1'b0;
        c.instr = curInstr;
        c.flag  = curFlag;
        c.ack   = ack;
        c.cont  = cont;
        c.exp   = o;
        c.tag   = curTag;
        traceQ.push_back(c);
    endtask

    task automatic addReset(input int n);
        cycle_t c;
        for (int i = 0; i < n; i++) begin
            c       = '0;
            c.rst   = 1'b1;
            c.instr = curInstr;
            c.tag   = curTag;
            traceQ.push_back(c);
        end
        modelCausa = 2'b00;
    endtask

    // A memory wait: 'delay' cycles without acknowledge, then the ack cycle
    // carrying the extra strobes; MAXW unanswered cycles end in a trap.
    task automatic addWait(input logic [3:0] st, input logic isWrite, input int delay,
                           input outs_t extra, output logic ok);
        outs_t w, f;
        w          = base(st);
        w.memRead  = !isWrite;
        w.memWrite = isWrite;
        if (delay >= MAXW) begin
            for (int i = 0; i < MAXW; i++) pushCycle(w, 1'b0, idleCont);
            modelCausa = 2'b10;
            f          = base(4'd12);
            f.trap     = 1'b1;
            f.loadPC   = 1'b1;
            f.selectPC = 2'b11;
            pushCycle(f, idleAck, idleCont);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < delay; i++) pushCycle(w, 1'b0, idleCont);
            f = w | extra;
            pushCycle(f, 1'b1, idleCont);
            ok = 1'b1;
        end
    endtask

    // Expected trace of one complete instruction.
    task automatic addInstr(input logic [15:0] ins, input int fDelay, input int dDelay,
                            input logic flag, input int haltCycles);
        outs_t      o, x;
        logic       ok;
        logic [3:0] op;
        logic [2:0] rd, ra, rb;
        curInstr = ins;
        curFlag  = flag;
        op = ins[15:12];
        rd = ins[8:6];
        ra = ins[5:3];
        rb = ins[2:0];
        o = base(4'd0);
        o.loadAR = 1'b1;
        pushCycle(o, idleAck, idleCont);
        x = '0;
        x.loadIR = 1'b1;
        x.loadPC = 1'b1;
        addWait(4'd1, 1'b0, fDelay, x, ok);
        if (!ok) return;
        pushCycle(base(4'd2), idleAck, idleCont);
        if (op[3] == 1'b0) begin
            o = base(4'd3);
            o.readA = ra;
            o.readB = rb;
            o.fun = {1'b0, op[2:0]};
            o.writeEnable = 1'b1;
            o.writeAddress = rd;
            o.loadS = 1'b1;
            pushCycle(o, idleAck, idleCont);
        end else if (op == 4'h8 || op == 4'h9) begin
            o = base(4'd4);
            o.readA = ra;
            o.selectAR = 1'b1;
            o.loadAR = 1'b1;
            pushCycle(o, idleAck, idleCont);
            if (op == 4'h8) begin
                x = '0;
                x.loadDR = 1'b1;
                addWait(4'd5, 1'b0, dDelay, x, ok);
                if (ok) begin
                    o = base(4'd6);
                    o.writeSelect = 1'b1;
                    o.writeEnable = 1'b1;
                    o.writeAddress = rd;
                    pushCycle(o, idleAck, idleCont);
                end
            end else begin
                o = base(4'd7);
                o.readB = rb;
                o.selectDR = 1'b1;
                o.loadDR = 1'b1;
                pushCycle(o, idleAck, idleCont);
                addWait(4'd8, 1'b1, dDelay, '0, ok);
            end
        end else if (op == 4'hA) begin
            o = base(4'd9);
            o.readA = ra;
            o.loadPC = 1'b1;
            o.selectPC = 2'b10;
            pushCycle(o, idleAck, idleCont);
        end else if (op == 4'hB) begin
            o = base(4'd10);
            if (flag) begin
                o.loadPC = 1'b1;
                o.selectPC = 2'b01;
            end
            pushCycle(o, idleAck, idleCont);
        end else if (op == 4'hF) begin
            o = base(4'd11);
            o.halted = 1'b1;
            for (int i = 0; i < haltCycles; i++) pushCycle(o, idleAck, 1'b0);
            pushCycle(o, idleAck, 1'b1);
        end else begin
            modelCausa = 2'b01;
            o = base(4'd12);
            o.trap = 1'b1;
            o.loadPC = 1'b1;
            o.selectPC = 2'b11;
            pushCycle(o, idleAck, idleCont);
        end
    endtask

    function automatic outs_t dutOuts();
        outs_t a;
        a.memRead = MemRead;          a.memWrite = MemWrite;
        a.loadIR = LoadIR;            a.loadAR = LoadAR;
        a.selectAR = SelectAR;        a.loadDR = LoadDR;
        a.selectDR = SelectDR;        a.loadPC = LoadPC;
        a.selectPC = SelectPC;        a.writeEnable = WriteEnable;
        a.writeSelect = WriteSelect;  a.writeAddress = WriteAddress;
        a.readA = ReadAddressA;       a.readB = ReadAddressB;
        a.fun = Fun;                  a.loadS = LoadS;
        a.halted = Halted;            a.trap = Trap;
        a.causa = Causa;              a.estado = Estado;
        return a;
    endfunction

    task automatic applyStimulus(input cycle_t c);
        Reiniciar   = c.rst;
        Instruccion = c.instr;
        StatusFlag  = c.flag;
        MemAck      = c.ack;
        Continuar   = c.cont;
    endtask

    task automatic checkOutput(input cycle_t c);
        outs_t a;
        a = dutOuts();
        checks++;
        if (a !== c.exp) begin
            errors++;
            $display("[TB] FAIL trace %0s cycle %0d: got %h expected %h", c.tag, cycleNo, a, c.exp);
        end
    endtask

    task automatic litCheck(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic stepLit(input logic rst, input logic [15:0] ins, input logic ack);
        @(posedge Reloj);
        #1;
        Reiniciar = rst; Instruccion = ins; MemAck = ack; StatusFlag = 1'b0; Continuar = 1'b0;
        @(negedge Reloj);
    endtask

    initial begin
        cycle_t c;
        outs_t  o;
        logic   ok;

        addReset(2);
        curTag = "alu";   idleAck = 1'b1; idleCont = 1'b0;
        addInstr(16'h309C, 0, 0, 1'b0, 0);
        addInstr(16'h7123, 1, 0, 1'b0, 0);
        curTag = "load";  idleAck = 1'b0;
        addInstr(16'h8068, 0, 3, 1'b0, 0);
        curTag = "store"; idleCont = 1'b1;
        addInstr(16'h9AD5, 2, 1, 1'b0, 0);
        curTag = "jump";
        addInstr(16'hA018, 0, 0, 1'b0, 0);
        curTag = "branch";
        addInstr(16'hB000, 0, 0, 1'b0, 0);
        addInstr(16'hB000, 0, 0, 1'b1, 0);
        curTag = "fetchTmo";
        addInstr(16'h309C, 15, 0, 1'b0, 0);
        curTag = "fetchLate";
        addInstr(16'h0000, 14, 0, 1'b0, 0);
        curTag = "illegal";
        addInstr(16'hD000, 0, 0, 1'b0, 0);
        addInstr(16'hE1FF, 0, 0, 1'b0, 0);
        curTag = "rdTmo";
        addInstr(16'h8068, 0, 15, 1'b0, 0);
        curTag = "wrTmo";
        addInstr(16'h9000, 0, 20, 1'b0, 0);
        curTag = "halt";  idleCont = 1'b0;
        addInstr(16'hF000, 0, 0, 1'b0, 9);

        // Load interrupted by reset in its third RD_WAIT cycle.
        curTag = "rstMid"; curInstr = 16'h8068;
        o = base(4'd0); o.loadAR = 1'b1;
        pushCycle(o, 1'b0, 1'b0);
        o = '0; o.loadIR = 1'b1; o.loadPC = 1'b1;
        addWait(4'd1, 1'b0, 0, o, ok);
        pushCycle(base(4'd2), 1'b0, 1'b0);
        o = base(4'd4); o.readA = 3'd5; o.selectAR = 1'b1; o.loadAR = 1'b1;
        pushCycle(o, 1'b0, 1'b0);
        o = base(4'd5); o.memRead = 1'b1;
        pushCycle(o, 1'b0, 1'b0);
        pushCycle(o, 1'b0, 1'b0);
        addReset(1);
        curTag = "afterRst";
        addInstr(16'h309C, 0, 0, 1'b0, 0);

        while (traceQ.size() > 0) begin
            c = traceQ.pop_front();
            @(posedge Reloj);
            #1;
            applyStimulus(c);
            @(negedge Reloj);
            checkOutput(c);
            cycleNo++;
        end

        // Hand-computed values for an ALU instruction followed by an illegal one.
        stepLit(1'b1, 16'h309C, 1'b1);
        litCheck("rstAllZero", 64'(dutOuts()), 64'd0);
        stepLit(1'b0, 16'h309C, 1'b1);
        litCheck("fetchEstado", 64'(Estado), 64'd0);
        litCheck("fetchLoadAR", 64'(LoadAR), 64'd1);
        stepLit(1'b0, 16'h309C, 1'b1);
        litCheck("fwLoadIR", 64'({MemRead, LoadIR, LoadPC}), 64'b111);
        stepLit(1'b0, 16'h309C, 1'b1);
        litCheck("decodeEstado", 64'(Estado), 64'd2);
        stepLit(1'b0, 16'h309C, 1'b1);
        litCheck("aluAddrs", 64'({WriteAddress, ReadAddressA, ReadAddressB}), 64'({3'd2, 3'd3, 3'd4}));
        litCheck("aluFun", 64'(Fun), 64'b0011);
        litCheck("aluWeLoadS", 64'({WriteEnable, LoadS, WriteSelect}), 64'b110);
        stepLit(1'b0, 16'hD000, 1'b1);
        litCheck("refetchEstado", 64'(Estado), 64'd0);
        stepLit(1'b0, 16'hD000, 1'b1);
        stepLit(1'b0, 16'hD000, 1'b1);
        litCheck("illegalDecode", 64'(Estado), 64'd2);
        stepLit(1'b0, 16'hD000, 1'b1);
        litCheck("trapState", 64'({Estado, Trap, LoadPC, SelectPC, Causa}), 64'({4'd12, 1'b1, 1'b1, 2'b11, 2'b01}));
        stepLit(1'b0, 16'hD000, 1'b1);
        litCheck("afterTrap", 64'({Estado, Trap, Causa}), 64'({4'd0, 1'b0, 2'b01}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
